// File: rtl/ram_wr_pkg.sv
// Shared types and constants for the RAM write sequencer.
// Request layout and sequencer state encoding.
package ram_wr_pkg;

   localparam int COL_W     = 4;
   localparam int NUM_COLS  = 16;
   localparam int MAX_ROW_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } state_e;

   // Row is carried at its widest size; unused upper bits stay zero.
   typedef struct packed {
      logic [MAX_ROW_W-1:0] row;
      logic [COL_W-1:0]     col;
      logic [7:0]           data;
   } req_t;

endpackage

// File: rtl/ram_wr_fifo.sv
// Request FIFO for the RAM write sequencer.
// Power-of-two depth, pointers wrap naturally.
module ram_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q;
   logic [AW-1:0] rp_q;
   logic [LW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == LW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign level_o = cnt_q;
   assign rdata_o = mem_q[rp_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage, pointers and occupancy; push+pop keeps the level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wp_q] <= wdata_i;
            wp_q        <= wp_q + AW'(1);
         end
         if (do_pop) rp_q <= rp_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + LW'(1);
            2'b01:   cnt_q <= cnt_q - LW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ram_wr_sequencer.sv
// Byte-cell RAM write sequencer: buffers requests, replays each
// as SETUP / STROBE / HOLD around a one-cycle cell write strobe.
module ram_wr_sequencer
   import ram_wr_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ROW_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ROW_W+3:0]         req_addr,
   input  logic [7:0]               req_data,
   output logic [7:0]               dm_in,
   output logic [3:0]               dm_sel,
   output logic                     dm_en,
   output logic [ROW_W-1:0]         wr_row,
   output logic                     cell_we,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy
);

   state_e           state_q;
   state_e           state_d;
   logic             pop;
   logic             full;
   logic             empty;
   req_t             wreq;
   req_t             head;
   logic [7:0]       dm_in_q;
   logic [3:0]       dm_sel_q;
   logic [ROW_W-1:0] wr_row_q;

   assign wreq.row  = MAX_ROW_W'(req_addr[ROW_W+3:COL_W]);
   assign wreq.col  = req_addr[COL_W-1:0];
   assign wreq.data = req_data;

   ram_wr_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(req_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (req_valid),
      .pop_i   (pop),
      .wdata_i (wreq),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level)
   );

   assign req_ready = !full;
   assign busy      = !empty || (state_q != IDLE);
   assign dm_en     = (state_q != IDLE);
   assign cell_we   = (state_q == STROBE);
   assign dm_in     = dm_in_q;
   assign dm_sel    = dm_sel_q;
   assign wr_row    = wr_row_q;

   // State register; reset drops dm_en/cell_we at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and FIFO pop; a new entry is taken only from IDLE or HOLD.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP:  state_d = STROBE;
         STROBE: state_d = HOLD;
         HOLD: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Demux data/select/row load only on a pop so they frame the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dm_in_q  <= '0;
         dm_sel_q <= '0;
         wr_row_q <= '0;
      end else if (pop) begin
         dm_in_q  <= head.data;
         dm_sel_q <= head.col;
         wr_row_q <= ROW_W'(head.row);
      end
   end

endmodule

// File: tb/tb_ram_wr_sequencer.sv
// Self-checking bench for ram_wr_sequencer.
// Scoreboard of accepted requests checked at every strobe.
module tb_ram_wr_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_addr;
   logic [7:0] req_data;
   logic [7:0] dm_in;
   logic [3:0] dm_sel;
   logic       dm_en;
   logic [3:0] wr_row;
   logic       cell_we;
   logic [2:0] fifo_level;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_str = 0;
   int en_run = 0;
   int en_max = 0;
   bit saw_full = 0;
   logic [15:0] sb [$];
   int          acc_cyc [$];
   int          str_cyc [$];
   logic [15:0] prev_v;
   bit          prev_we = 0;

   ram_wr_sequencer #(.DEPTH(4), .ROW_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .dm_in      (dm_in),
      .dm_sel     (dm_sel),
      .dm_en      (dm_en),
      .wr_row     (wr_row),
      .cell_we    (cell_we),
      .fifo_level (fifo_level),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst_n && req_valid && req_ready) begin
         sb.push_back({req_addr, req_data});
         acc_cyc.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      logic [15:0] v;
      v = {wr_row, dm_sel, dm_in};
      if (!rst_n) begin
         prev_we = 0;
         en_run  = 0;
      end else begin
         if (fifo_level == 3'd4) begin
            saw_full = 1;
            chk("ready_full", req_ready, 0);
         end
         if (prev_we) chk("post_stable", v, prev_v);
         if (cell_we) begin
            n_str++;
            str_cyc.push_back(cyc);
            chk("pre_stable", v, prev_v);
            chk("we_en", dm_en, 1);
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else chk("sb_data", v, sb.pop_front());
         end
         if (dm_en) begin
            en_run++;
            if (en_run > en_max) en_max = en_run;
         end else begin
            en_run = 0;
         end
         prev_v  = v;
         prev_we = cell_we;
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] d,
                       output int stalls);
      logic r;
      stalls    = 0;
      req_valid = 1;
      req_addr  = a;
      req_data  = d;
      for (int i = 0; i < 50; i++) begin
         r = req_ready;
         @(negedge clk);
         if (r) break;
         stalls++;
      end
      if (stalls >= 50) chk("send_timeout", 1, 0);
      req_valid = 0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 1, 0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int st;
      int s0;
      int stall_sum;
      int k;
      rst_n     = 0;
      req_valid = 0;
      req_addr  = 0;
      req_data  = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("rst_dm_in", dm_in, 0);
      chk("rst_dm_sel", dm_sel, 0);
      chk("rst_wr_row", wr_row, 0);
      chk("rst_dm_en", dm_en, 0);
      chk("rst_cell_we", cell_we, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 1);

      send(8'h13, 8'hA5, st);
      chk("s_level", fifo_level, 1);
      chk("s_en0", dm_en, 0);
      chk("s_busy", busy, 1);
      @(negedge clk);
      chk("s_setup_en", dm_en, 1);
      chk("s_setup_we", cell_we, 0);
      chk("s_sel", dm_sel, 3);
      chk("s_row", wr_row, 1);
      chk("s_data", dm_in, 8'hA5);
      @(negedge clk);
      chk("s_strobe_we", cell_we, 1);
      @(negedge clk);
      chk("s_hold_we", cell_we, 0);
      chk("s_hold_en", dm_en, 1);
      @(negedge clk);
      chk("s_idle_en", dm_en, 0);
      chk("s_idle_busy", busy, 0);
      chk("s_idle_sel", dm_sel, 3);

      s0 = n_str;
      en_max = 0;
      stall_sum = 0;
      for (int i = 0; i < 4; i++) begin
         send(8'h20 + 8'(i * 17), 8'h40 + 8'(i), st);
         stall_sum += st;
      end
      wait_idle();
      chk("b_stalls", stall_sum, 0);
      chk("b_strobes", n_str - s0, 4);
      chk("b_en_run", en_max, 12);
      k = str_cyc.size();
      for (int i = 1; i < 4; i++)
         chk("b_spacing", str_cyc[k-4+i] - str_cyc[k-5+i], 3);

      s0 = n_str;
      saw_full = 0;
      acc_cyc.delete();
      for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 8'hC0 + 8'(i), st);
      wait_idle();
      chk("h_full_seen", saw_full, 1);
      chk("h_accepts", acc_cyc.size(), 8);
      chk("h_sp6", acc_cyc[6] - acc_cyc[5], 3);
      chk("h_sp7", acc_cyc[7] - acc_cyc[6], 3);
      chk("h_strobes", n_str - s0, 8);
      chk("h_sb_left", sb.size(), 0);

      send(8'h31, 8'h01, st);
      send(8'h32, 8'h02, st);
      send(8'h33, 8'h03, st);
      chk("r_pre_we", cell_we, 1);
      chk("r_pre_level", fifo_level, 2);
      #1 rst_n = 0;
      #1;
      chk("r_async_we", cell_we, 0);
      chk("r_async_en", dm_en, 0);
      chk("r_async_lvl", fifo_level, 0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      s0 = n_str;
      repeat (10) @(negedge clk);
      chk("r_no_strobe", n_str - s0, 0);
      chk("r_level", fifo_level, 0);
      chk("r_busy", busy, 0);

      s0 = n_str;
      send(8'h05, 8'h11, st);
      send(8'h06, 8'h22, st);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("g_strobes", n_str - s0, 2);
      chk("g_en", dm_en, 0);
      chk("g_data", dm_in, 8'h22);
      chk("g_sel", dm_sel, 6);

      s0 = n_str;
      for (int i = 0; i < 6; i++) begin
         send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), st);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      chk("x_strobes", n_str - s0, 6);
      chk("x_sb_left", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
